bp_gshare: RTL

Parametrised branch prediction unit for the RV32I pipeline: a direct-mapped branch target buffer (BTB) plus a gshare pattern history table (PHT) of saturating counters, indexed by PC XOR a speculative global history register (GHR). Fetch sees a same-cycle next-PC prediction. EX sends back a resolved-branch update that trains the tables and repairs the GHR on mispredict. It sits beside `pc`/`If`, and is configurable in table depths, history length and counter width.

---
 rtl/bp_gshare_pkg.sv | 28 ++
 rtl/bp_gshare_sat_counter_upd.sv | 23 ++
 rtl/bp_gshare.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bp_gshare_pkg.sv
// Shared widths, defaults and counter constants for the gshare branch predictor.
package bp_gshare_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int BTB_IDX_W_DEF = 6;
  localparam int PHT_IDX_W_DEF = 8;
  localparam int GHR_W_DEF     = 8;
  localparam int CNT_W_DEF     = 2;

  // Instructions are word aligned: PC bits below PC_LSB never index a table.
  localparam int PC_LSB     = 2;
  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    GHR_HOLD   = 2'd0,
    GHR_SPEC   = 2'd1,
    GHR_REPAIR = 2'd2
  } ghr_src_e;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  function automatic int unsigned cnt_weak_nt(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_gshare_sat_counter_upd.sv
// Combinational saturating up/down step for one PHT counter.
module sat_counter_upd
  import bp_gshare_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             up_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  always_comb begin
    cnt_o = cnt_i;
    if (up_i) begin
      if (cnt_i != CNT_MAX) cnt_o = cnt_i + 1'b1;
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - 1'b1;
    end
  end

endmodule

// File: rtl/bp_gshare.sv
// BTB + gshare PHT branch predictor: same-cycle fetch prediction, EX-side training
// and speculative global history with mispredict repair.
module bp_gshare
  import bp_gshare_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int BTB_IDX_W = BTB_IDX_W_DEF,
  parameter int PHT_IDX_W = PHT_IDX_W_DEF,
  parameter int GHR_W     = GHR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             fetch_fire_i,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_pc_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_is_cond_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_mispred_i,
  output logic [31:0]      mispred_cnt_o
);

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int TAG_W = XLEN - BTB_IDX_W - PC_LSB;
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_nt(CNT_W));

  logic             btb_valid_q [BTB_N];
  logic             btb_valid_d [BTB_N];
  logic [TAG_W-1:0] btb_tag_q   [BTB_N];
  logic [TAG_W-1:0] btb_tag_d   [BTB_N];
  logic             btb_cond_q  [BTB_N];
  logic             btb_cond_d  [BTB_N];
  logic [XLEN-1:0]  btb_tgt_q   [BTB_N];
  logic [XLEN-1:0]  btb_tgt_d   [BTB_N];
  logic [CNT_W-1:0] pht_q       [PHT_N];
  logic [CNT_W-1:0] pht_d       [PHT_N];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;

  logic [BTB_IDX_W-1:0] f_btb_idx, u_btb_idx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic [PHT_IDX_W-1:0] f_pht_idx, u_pht_idx;
  logic                 f_hit, f_dir, f_cond_hit;
  logic [CNT_W-1:0]     u_cnt_nxt;
  logic [GHR_W:0]       spec_cat, rep_cat;
  ghr_src_e             ghr_src;

  assign f_btb_idx = pc_i[BTB_IDX_W+PC_LSB-1:PC_LSB];
  assign f_tag     = pc_i[XLEN-1:BTB_IDX_W+PC_LSB];
  assign f_pht_idx = pc_i[PHT_IDX_W+PC_LSB-1:PC_LSB] ^ PHT_IDX_W'(ghr_q);
  assign f_hit     = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
  assign f_dir     = pht_q[f_pht_idx][CNT_W-1];
  assign f_cond_hit = f_hit && btb_cond_q[f_btb_idx];

  assign pred_taken_o  = f_hit && (!btb_cond_q[f_btb_idx] || f_dir);
  assign pred_pc_o     = pred_taken_o ? btb_tgt_q[f_btb_idx] : pc_i + XLEN'(INSN_BYTES);
  assign pred_ghr_o    = ghr_q;
  assign mispred_cnt_o = mispred_cnt_q;

  assign u_btb_idx = upd_pc_i[BTB_IDX_W+PC_LSB-1:PC_LSB];
  assign u_tag     = upd_pc_i[XLEN-1:BTB_IDX_W+PC_LSB];
  assign u_pht_idx = upd_pc_i[PHT_IDX_W+PC_LSB-1:PC_LSB] ^ PHT_IDX_W'(upd_ghr_i);

  sat_counter_upd #(.CNT_W(CNT_W)) u_sat (
    .cnt_i (pht_q[u_pht_idx]),
    .up_i  (upd_taken_i),
    .cnt_o (u_cnt_nxt)
  );

  // Concatenate-then-truncate keeps the shift legal even for a 1-bit history.
  assign spec_cat = {ghr_q, f_dir};
  assign rep_cat  = {upd_ghr_i, upd_taken_i};

  logic unused_bits;
  assign unused_bits = ^{pc_i[PC_LSB-1:0], upd_pc_i[PC_LSB-1:0], spec_cat[GHR_W], rep_cat[GHR_W]};

  always_comb begin
    ghr_src = GHR_HOLD;
    if (fetch_fire_i && f_cond_hit) ghr_src = GHR_SPEC;
    if (upd_valid_i && upd_mispred_i) ghr_src = GHR_REPAIR;
  end

  always_comb begin
    btb_valid_d   = btb_valid_q;
    btb_tag_d     = btb_tag_q;
    btb_cond_d    = btb_cond_q;
    btb_tgt_d     = btb_tgt_q;
    pht_d         = pht_q;
    ghr_d         = ghr_q;
    mispred_cnt_d = mispred_cnt_q;
    if (rdy) begin
      if (flush_i) begin
        for (int i = 0; i < BTB_N; i++) btb_valid_d[i] = 1'b0;
      end
      // The fill lands after the flush so the written entry survives fence.i.
      if (upd_valid_i && upd_taken_i) begin
        btb_valid_d[u_btb_idx] = 1'b1;
        btb_tag_d[u_btb_idx]   = u_tag;
        btb_cond_d[u_btb_idx]  = upd_is_cond_i;
        btb_tgt_d[u_btb_idx]   = upd_target_i;
      end
      if (upd_valid_i && upd_is_cond_i) pht_d[u_pht_idx] = u_cnt_nxt;
      if (upd_valid_i && upd_mispred_i) mispred_cnt_d = mispred_cnt_q + 32'd1;
      case (ghr_src)
        GHR_SPEC:   ghr_d = spec_cat[GHR_W-1:0];
        GHR_REPAIR: ghr_d = upd_is_cond_i ? rep_cat[GHR_W-1:0] : upd_ghr_i;
        default:    ghr_d = ghr_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) btb_valid_q[i] <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CNT_WNT;
      ghr_q         <= '0;
      mispred_cnt_q <= '0;
    end else begin
      btb_valid_q   <= btb_valid_d;
      pht_q         <= pht_d;
      ghr_q         <= ghr_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // BTB payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    btb_tag_q  <= btb_tag_d;
    btb_cond_q <= btb_cond_d;
    btb_tgt_q  <= btb_tgt_d;
  end

endmodule
